// File: rtl/apb_bank_pkg.sv
// Shared types, error cause codes and select-legality helper for the APB completer bank.
package apb_bank_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    localparam int unsigned MAX_SLV   = 32;
    localparam int unsigned DEF_DEPTH = 16;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_SEL   = 2'd1;
    localparam logic [1:0] ERR_ALIGN = 2'd2;
    localparam logic [1:0] ERR_RANGE = 2'd3;

    // A legal select has exactly one bit set.
    function automatic logic onehot_ok(input logic [MAX_SLV-1:0] sel);
        return (sel != '0) && ((sel & (sel - MAX_SLV'(1))) == '0);
    endfunction

endpackage

// File: rtl/apb_slave_bank_if.sv
// APB bus between a requester and the completer bank.
interface apb_slave_bank_if #(
    parameter int unsigned NUM_SLV = 3,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32
);
    logic [NUM_SLV-1:0] Pselx;
    logic               Penable;
    logic               Pwrite;
    logic [ADDR_W-1:0]  Paddr;
    logic [DATA_W-1:0]  Pwdata;
    logic [DATA_W-1:0]  Prdata;
    logic               Pready;
    logic               Pslverr;

    modport master (
        output Pselx, Penable, Pwrite, Paddr, Pwdata,
        input  Prdata, Pready, Pslverr
    );

    modport slave (
        input  Pselx, Penable, Pwrite, Paddr, Pwdata,
        output Prdata, Pready, Pslverr
    );
endinterface

// File: rtl/apb_reg_bank.sv
// DEPTH x DATA_W register file: synchronous reset to a fixed value, one write port, combinational read.
module apb_reg_bank #(
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       DEPTH      = 16,
    parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= RESET_DATA;
        end else if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/apb_slave_bank.sv
// APB completer bank: NUM_SLV register files behind a phase FSM with wait states and error response.
module apb_slave_bank
    import apb_bank_pkg::*;
#(
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       NUM_SLV    = 3,
    parameter int unsigned       DEPTH      = DEF_DEPTH,
    parameter int unsigned       WAIT_CYC   = 0,
    parameter logic [DATA_W-1:0] RESET_DATA = DATA_W'(32'h1111_1111)
) (
    input  logic             Hclk,
    input  logic             Hreset,
    apb_slave_bank_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] ST_IDLE   = 2'(IDLE);
    localparam logic [1:0] ST_SETUP  = 2'(SETUP);
    localparam logic [1:0] ST_ACCESS = 2'(ACCESS);

    logic [1:0]         state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt, cnt_eff;
    logic               any_sel, in_access, done_c, proto_err_c, dec_err;
    logic [1:0]         err_cause;
    logic [IDX_W-1:0]   idx;
    logic [NUM_SLV-1:0] we;
    logic [DATA_W-1:0]  rdata [NUM_SLV];
    logic [DATA_W-1:0]  rd_mux;

    assign any_sel = |bus.Pselx;
    assign idx     = bus.Paddr[2 +: IDX_W];

    // SETUP records that the setup phase was seen; the cycle Penable rises there is
    // already the first access cycle, so a zero-wait transfer completes in two cycles.
    assign cnt_eff     = (state == ST_ACCESS) ? cnt : '0;
    assign in_access   = any_sel & bus.Penable & ((state == ST_SETUP) | (state == ST_ACCESS));
    assign done_c      = in_access & (cnt_eff == CNT_W'(WAIT_CYC));
    assign proto_err_c = (state == ST_IDLE) & bus.Penable;

    // Address/select decode; first failing rule names the cause.
    always_comb begin
        err_cause = ERR_NONE;
        if (!onehot_ok(MAX_SLV'(bus.Pselx)))
            err_cause = ERR_SEL;
        else if (bus.Paddr[1:0] != 2'b00)
            err_cause = ERR_ALIGN;
        else if ((bus.Paddr >> (2 + IDX_W)) != '0)
            err_cause = ERR_RANGE;
    end

    assign dec_err = (err_cause != ERR_NONE);
    assign we      = {NUM_SLV{done_c & bus.Pwrite & !dec_err}} & bus.Pselx;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (any_sel && !bus.Penable) state_nxt = ST_SETUP;
            end
            ST_SETUP, ST_ACCESS: begin
                if (!any_sel) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (!bus.Penable) begin
                    if (state == ST_ACCESS) begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                    end
                end else if (done_c) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    state_nxt = ST_ACCESS;
                    cnt_nxt   = cnt_eff + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    for (genvar g = 0; g < int'(NUM_SLV); g++) begin : g_bank
        apb_reg_bank #(
            .DATA_W     (DATA_W),
            .DEPTH      (DEPTH),
            .RESET_DATA (RESET_DATA)
        ) u_bank (
            .clk   (Hclk),
            .rst   (Hreset),
            .we    (we[g]),
            .idx   (idx),
            .wdata (bus.Pwdata),
            .rdata (rdata[g])
        );
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < int'(NUM_SLV); i++)
            if (bus.Pselx[i]) rd_mux = rd_mux | rdata[i];
    end

    // Responses are suppressed while reset is held so a dropped transfer never completes.
    assign bus.Pready  = !Hreset & (done_c | proto_err_c);
    assign bus.Pslverr = !Hreset & (proto_err_c | (done_c & dec_err));
    assign bus.Prdata  = (!Hreset & done_c & !bus.Pwrite & !dec_err) ? rd_mux : '0;

endmodule
